// File: rtl/tpu_pkg.sv
// Shared types for the TPU output path: FP16 element type, writeback FSM
// states and the magnitude mask used for zero detection.
package tpu_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } relu_wb_state_e;

  localparam logic [14:0] FP16_ZERO_MASK = 15'h7FFF;

  // +0 and -0 both count as zero; the sign bit is ignored
  function automatic logic fp16_is_zero(input fp16_t v);
    return (v[14:0] & FP16_ZERO_MASK) == 15'd0;
  endfunction

endpackage

// File: rtl/relu_writeback_if.sv
// Element stream from relu and the write port towards the output SRAM.
// Handshake rule for both: a transfer happens on a rising clk edge where the
// producer's valid/we and the consumer's ready are both high; the producer
// holds its payload stable while it waits for ready.
interface relu_wb_stream_if;
  import tpu_pkg::*;

  logic  in_valid;
  fp16_t in_data;
  logic  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

interface relu_wb_mem_if #(
  parameter int PACK   = 4,
  parameter int ADDR_W = 10
);
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [16*PACK-1:0]  mem_wdata;
  logic                mem_ready;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/relu_wb_packer.sv
// Lane registers and lane index for packing PACK FP16 elements into one word.
// `word` is the packed word as it will look once the element on `data` lands.
module relu_wb_packer
  import tpu_pkg::*;
#(
  parameter int PACK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  fp16_t              data,
  output logic               full,
  output logic [16*PACK-1:0] word
);

  localparam int LW = $clog2(PACK);
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);
  localparam logic [LW-1:0] LANE_ONE  = LW'(1);

  fp16_t         lanes_q [PACK];
  logic [LW-1:0] lane_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PACK; k++) lanes_q[k] <= '0;
      lane_idx <= '0;
    end else if (clear) begin
      for (int k = 0; k < PACK; k++) lanes_q[k] <= '0;
      lane_idx <= '0;
    end else if (load) begin
      lanes_q[lane_idx] <= data;
      lane_idx          <= (lane_idx == LAST_LANE) ? '0 : lane_idx + LANE_ONE;
    end
  end

  // High when the next accepted element completes the word
  assign full = (lane_idx == LAST_LANE);

  always_comb begin
    word = '0;
    for (int k = 0; k < PACK; k++) begin
      word[16*k +: 16] = (lane_idx == LW'(k)) ? data : lanes_q[k];
    end
  end

endmodule

// File: rtl/relu_writeback.sv
// Packs the relu FP16 stream into PACK-wide words and writes them to the
// output SRAM at sequential addresses, one job of num_words words per start.
// Optional zero-element counter: define RELU_WB_ZERO_CNT_EN.
module relu_writeback
  import tpu_pkg::*;
#(
  parameter int PACK   = 4,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_words,
  relu_wb_stream_if.slave     up,
  relu_wb_mem_if.master       sram,
  output logic                busy,
  output logic                done,
`ifdef RELU_WB_ZERO_CNT_EN
  output logic [ADDR_W+$clog2(PACK):0] zero_cnt,
`endif
  output relu_wb_state_e      dbg_state
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  relu_wb_state_e     state;
  logic [ADDR_W:0]    num_q;
  logic [ADDR_W:0]    word_cnt;
  logic [ADDR_W:0]    word_cnt_inc;
  logic               accept;
  logic               pk_clear;
  logic               pk_full;
  logic [16*PACK-1:0] pk_word;

  assign accept       = (state == FILL) && up.in_valid && up.in_ready;
  assign pk_clear     = (state == IDLE) && start;
  assign word_cnt_inc = word_cnt + CNT_ONE;
  assign dbg_state    = state;

  relu_wb_packer #(.PACK(PACK)) u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (pk_clear),
    .load  (accept),
    .data  (up.in_data),
    .full  (pk_full),
    .word  (pk_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      up.in_ready    <= 1'b0;
      sram.mem_we    <= 1'b0;
      sram.mem_addr  <= '0;
      sram.mem_wdata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      num_q          <= '0;
      word_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            num_q         <= num_words;
            word_cnt      <= '0;
            sram.mem_addr <= base_addr;
            busy          <= 1'b1;
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= FILL;
              up.in_ready <= 1'b1;
            end
          end
        end

        FILL: begin
          // The completed word is registered here so the SRAM sees it intact
          if (accept && pk_full) begin
            state          <= WRITE;
            up.in_ready    <= 1'b0;
            sram.mem_we    <= 1'b1;
            sram.mem_wdata <= pk_word;
          end
        end

        WRITE: begin
          if (sram.mem_ready) begin
            sram.mem_we   <= 1'b0;
            sram.mem_addr <= sram.mem_addr + ADDR_ONE;
            word_cnt      <= word_cnt_inc;
            if (word_cnt_inc == num_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= FILL;
              up.in_ready <= 1'b1;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef RELU_WB_ZERO_CNT_EN
  localparam int ZW = ADDR_W + 1 + $clog2(PACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
    end else if (pk_clear) begin
      zero_cnt <= '0;
    end else if (accept && fp16_is_zero(up.in_data)) begin
      zero_cnt <= zero_cnt + ZW'(1);
    end
  end
`else
  // No sparsity counter in this build
`endif

endmodule

// File: tb/tb_relu_writeback.sv
// Bench for relu_writeback: table vectors, hand sequences for stall, start
// during FILL and mid-job reset, then random jobs against a packing model.
module tb_relu_writeback;
  import tpu_pkg::*;

  localparam int PACK   = 4;
  localparam int ADDR_W = 10;
  localparam int DW     = 16 * PACK;
  localparam int SW     = ADDR_W + DW;
  localparam int ZW     = ADDR_W + 1 + $clog2(PACK);
  localparam int NVEC   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_words;
  logic              busy;
  logic              done;
  relu_wb_state_e    dbg_state;
`ifdef RELU_WB_ZERO_CNT_EN
  logic [ZW-1:0]     zero_cnt;
`endif

  relu_wb_stream_if                                   up_if ();
  relu_wb_mem_if #(.PACK(PACK), .ADDR_W(ADDR_W))      mem_if ();

  relu_writeback #(.PACK(PACK), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .up        (up_if),
    .sram      (mem_if),
    .busy      (busy),
    .done      (done),
`ifdef RELU_WB_ZERO_CNT_EN
    .zero_cnt  (zero_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [SW-1:0] exp_q[$];
  logic [15:0]   elem_q[$];
  bit            zero_job = 1'b0;
  bit            prev_stall, prev_acc, prev_done;
  logic [SW-1:0] prev_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_acc   = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_we_held", mem_if.mem_we, 1);
        check("stall_addr_data_held", {mem_if.mem_addr, mem_if.mem_wdata}, prev_word);
        check("stall_in_ready_low", up_if.in_ready, 0);
      end
      if (done) begin
        check("done_after_last_write", prev_acc | zero_job, 1);
        check("done_one_cycle", prev_done, 0);
      end
      if (mem_if.mem_we && mem_if.mem_ready) begin
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("write_addr_data", {mem_if.mem_addr, mem_if.mem_wdata}, exp_q.pop_front());
      end
      prev_acc   = mem_if.mem_we && mem_if.mem_ready;
      prev_stall = mem_if.mem_we && !mem_if.mem_ready;
      prev_word  = {mem_if.mem_addr, mem_if.mem_wdata};
      prev_done  = done;
    end
  end

  // ---------------- drivers ----------------
  task automatic start_job(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ADDR_W'($urandom); num_words = (ADDR_W + 1)'($urandom);
  endtask

  task automatic feed(input logic [15:0] d);
    up_if.in_valid = 1'b1; up_if.in_data = d;
    @(negedge clk);
    check("feed_in_ready", up_if.in_ready, 1);
    @(posedge clk); #1;
    up_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen = 1'b0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("wait_done", seen, 1);
    @(posedge clk); #1;
  endtask

  // Streams elem_q with random gaps and SRAM stalls until done; cyc counts
  // the cycles from FILL entry to the done cycle.
  task automatic run_job(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                         input int gap, input int stall, output int cyc);
    bit got_done = 1'b0;
    start_job(b, n);
    cyc = 0;
    while (!got_done && cyc < 3000) begin
      up_if.in_valid   = (elem_q.size() != 0) && ($urandom_range(99) >= gap);
      up_if.in_data    = up_if.in_valid ? elem_q[0] : 16'($urandom);
      mem_if.mem_ready = ($urandom_range(99) >= stall);
      @(negedge clk);
      check("busy_in_job", busy, 1);
      if (up_if.in_valid && up_if.in_ready) void'(elem_q.pop_front());
      if (done) got_done = 1'b1;
      else cyc++;
      @(posedge clk); #1;
    end
    up_if.in_valid = 1'b0; mem_if.mem_ready = 1'b0;
    check("job_done_seen", got_done, 1);
    @(negedge clk);
    check("idle_busy_low", busy, 0);
    check("idle_done_low", done, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   nw;
    logic [2*DW-1:0]   elems;   // element k at bits [16k+15:16k]
    logic [7:0]        gap;
    logic [7:0]        stall;
    logic [ADDR_W-1:0] a0;
    logic [DW-1:0]     d0;
    logic [ADDR_W-1:0] a1;
    logic [DW-1:0]     d1;
    logic [ZW-1:0]     zeros;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [15:0] bp_e [4];

  initial begin
    int cyc;
    start = 1'b0; base_addr = '0; num_words = '0;
    up_if.in_valid = 1'b0; up_if.in_data = '0; mem_if.mem_ready = 1'b0;

    vecs[0] = '{base: 10'h010, nw: 11'd2, elems: 128'h0004_0003_0002_0001_4400_4200_4000_3C00,
                gap: 8'd0, stall: 8'd0, a0: 10'h010, d0: 64'h4400_4200_4000_3C00,
                a1: 10'h011, d1: 64'h0004_0003_0002_0001, zeros: '0};
    vecs[1] = '{base: 10'h3FF, nw: 11'd2, elems: 128'h8888_7777_6666_5555_4444_3333_2222_1111,
                gap: 8'd0, stall: 8'd0, a0: 10'h3FF, d0: 64'h4444_3333_2222_1111,
                a1: 10'h000, d1: 64'h8888_7777_6666_5555, zeros: '0};
    vecs[2] = '{base: 10'h123, nw: 11'd2, elems: 128'h0017_0016_0015_0014_0013_0012_0011_0010,
                gap: 8'd60, stall: 8'd0, a0: 10'h123, d0: 64'h0013_0012_0011_0010,
                a1: 10'h124, d1: 64'h0017_0016_0015_0014, zeros: '0};
    vecs[3] = '{base: 10'h200, nw: 11'd1, elems: 128'h0000_3C00_8000_0000,
                gap: 8'd0, stall: 8'd0, a0: 10'h200, d0: 64'h0000_3C00_8000_0000,
                a1: '0, d1: '0, zeros: ZW'(3)};
    vecs[4] = '{base: 10'h155, nw: 11'd1, elems: 128'h8001_FC00_7C00_FFFF,
                gap: 8'd20, stall: 8'd60, a0: 10'h155, d0: 64'h8001_FC00_7C00_FFFF,
                a1: '0, d1: '0, zeros: '0};
    vecs[5] = '{base: 10'h077, nw: 11'd0, elems: '0,
                gap: 8'd0, stall: 8'd0, a0: '0, d0: '0, a1: '0, d1: '0, zeros: '0};

    // Reset values
    apply_reset();
    @(negedge clk);
    check("rst_in_ready", up_if.in_ready, 0);
    check("rst_mem_we", mem_if.mem_we, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    check("rst_mem_wdata", mem_if.mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, IDLE);
`ifdef RELU_WB_ZERO_CNT_EN
    check("rst_zero_cnt", zero_cnt, 0);
`endif

    // Table vectors
    for (int i = 0; i < NVEC; i++) begin
      vec_t v;
      v = vecs[i];
      elem_q.delete();
      for (int k = 0; k < int'(v.nw) * PACK; k++) elem_q.push_back(16'(v.elems >> (16 * k)));
      if (v.nw >= 1) exp_q.push_back({v.a0, v.d0});
      if (v.nw >= 2) exp_q.push_back({v.a1, v.d1});
      zero_job = (v.nw == 0);
      run_job(v.base, v.nw, int'(v.gap), int'(v.stall), cyc);
      zero_job = 1'b0;
      check($sformatf("vec%0d_writes_drained", i), exp_q.size(), 0);
      check($sformatf("vec%0d_elems_used", i), elem_q.size(), 0);
      if (v.gap == 0 && v.stall == 0)
        check($sformatf("vec%0d_latency", i), cyc, int'(v.nw) * (PACK + 1));
`ifdef RELU_WB_ZERO_CNT_EN
      check($sformatf("vec%0d_zero_cnt", i), zero_cnt, v.zeros);
`endif
    end

    // Backpressure: five stalled cycles, then exactly one write
    bp_e = '{16'h4567, 16'h0123, 16'hBEEF, 16'hDEAD};
    exp_q.push_back({10'h080, 64'hDEAD_BEEF_0123_4567});
    mem_if.mem_ready = 1'b0;
    start_job(10'h080, 11'd1);
    for (int k = 0; k < 4; k++) feed(bp_e[k]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_we", mem_if.mem_we, 1);
      check("bp_addr", mem_if.mem_addr, 10'h080);
      check("bp_data", mem_if.mem_wdata, 64'hDEAD_BEEF_0123_4567);
      check("bp_in_ready", up_if.in_ready, 0);
      @(posedge clk); #1;
    end
    mem_if.mem_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    mem_if.mem_ready = 1'b0;
    @(negedge clk);
    check("bp_done", done, 1);
    check("bp_busy_in_done", busy, 1);
    check("bp_single_write", exp_q.size(), 0);
    @(negedge clk);
    check("bp_done_cleared", done, 0);
    check("bp_idle_busy", busy, 0);

    // start during FILL is ignored
    mem_if.mem_ready = 1'b1;
    exp_q.push_back({10'h020, 64'h0A04_0A03_0A02_0A01});
    start_job(10'h020, 11'd1);
    feed(16'h0A01);
    feed(16'h0A02);
    start = 1'b1; base_addr = 10'h3C0; num_words = 11'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("fill_start_state", dbg_state, FILL);
    @(posedge clk); #1;
    feed(16'h0A03);
    feed(16'h0A04);
    wait_done(10);
    check("fill_start_writes", exp_q.size(), 0);
    check("fill_start_next_addr", mem_if.mem_addr, 10'h021);
    mem_if.mem_ready = 1'b0;

    // Reset after two lanes: nothing written, everything back to reset values
    start_job(10'h040, 11'd1);
    feed(16'h1111);
    feed(16'h2222);
    mem_if.mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", up_if.in_ready, 0);
    check("mid_rst_mem_we", mem_if.mem_we, 0);
    check("mid_rst_mem_addr", mem_if.mem_addr, 0);
    check("mid_rst_mem_wdata", mem_if.mem_wdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_state", dbg_state, IDLE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_write", mem_if.mem_we, 0);
    mem_if.mem_ready = 1'b0;

    // Fresh job after reset; zero count of +0, -0, 1.0, +0
    elem_q.delete();
    elem_q.push_back(16'h0000); elem_q.push_back(16'h8000);
    elem_q.push_back(16'h3C00); elem_q.push_back(16'h0000);
    exp_q.push_back({10'h200, 64'h0000_3C00_8000_0000});
    run_job(10'h200, 11'd1, 0, 0, cyc);
    check("post_rst_writes", exp_q.size(), 0);
`ifdef RELU_WB_ZERO_CNT_EN
    check("post_rst_zero_cnt", zero_cnt, 3);
`endif

    // Random jobs against the packing model
    for (int j = 0; j < 20; j++) begin
      logic [ADDR_W-1:0] b;
      logic [ADDR_W:0]   n;
      logic [DW-1:0]     word;
      logic [15:0]       e;
      int                zc, g, st;
      b  = ADDR_W'($urandom);
      n  = (ADDR_W + 1)'($urandom_range(0, 4));
      g  = $urandom_range(0, 60);
      st = $urandom_range(0, 60);
      zc = 0;
      elem_q.delete();
      for (int w = 0; w < int'(n); w++) begin
        word = '0;
        for (int k = 0; k < PACK; k++) begin
          if ($urandom_range(0, 3) == 0) e = $urandom_range(0, 1) ? 16'h8000 : 16'h0000;
          else e = 16'($urandom);
          if (e[14:0] == 15'd0) zc++;
          elem_q.push_back(e);
          word = word | (DW'(e) << (16 * k));
        end
        exp_q.push_back({ADDR_W'(int'(b) + w), word});
      end
      zero_job = (n == 0);
      run_job(b, n, g, st, cyc);
      zero_job = 1'b0;
      check($sformatf("rnd%0d_writes_drained", j), exp_q.size(), 0);
      check($sformatf("rnd%0d_elems_used", j), elem_q.size(), 0);
`ifdef RELU_WB_ZERO_CNT_EN
      check($sformatf("rnd%0d_zero_cnt", j), zero_cnt, ZW'(zc));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/relu_writeback.md
# relu_writeback

Output-side stage directly downstream of `relu`. It accepts the FP16 activation stream `z` one element per handshake and packs `PACK` consecutive elements into one wide word. It writes each packed word to the output activation SRAM at sequential addresses starting from a programmed base. It runs one job of `num_words` words per `start` pulse and signals completion with a one-cycle `done`.

## Interface
- `PACK`, 4, FP16 elements per memory word (≥2, power of two)
- `ADDR_W`, 10, SRAM address width
- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset
- `start` in 1, job launch; sampled only in IDLE
- `base_addr` in ADDR_W, first write address; latched on `start`
- `num_words` in ADDR_W+1, words in job; latched on `start`
- `in_valid` in 1, upstream element valid
- `in_data` in 16, FP16 element (from `relu.z`)
- `in_ready` out 1, stage can accept element
- `mem_we` out 1, SRAM write request
- `mem_addr` out ADDR_W, write address
- `mem_wdata` out 16*PACK, packed word; lane k at bits [16k+15:16k]
- `mem_ready` in 1, SRAM accepts write this cycle
- `busy` out 1, job in progress
- `done` out 1, one-cycle completion pulse
- `zero_cnt` out ADDR_W+1+clog2(PACK), zero-element count (only with macro)

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- **IDLE**
  - `start`=1 latches `base_addr` and `num_words`, clears the lane index and word counter.
  - Goes to FILL, or to DONE if `num_words`==0.
- **FILL**
  - `in_ready`=1.
  - Each `in_valid&&in_ready` stores `in_data` in lane `lane_idx`, then `lane_idx` increments.
  - On accepting lane PACK-1, goes to WRITE and `lane_idx` wraps to 0.
- **WRITE**
  - `mem_we`=1 and `in_ready`=0.
  - `mem_addr`/`mem_wdata` are held stable until `mem_ready`=1.
  - On acceptance, the address increments modulo 2^ADDR_W (wrap permitted, no error) and the word counter increments.
  - Goes to DONE if the counter reaches `num_words`, else back to FILL.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in FILL and WRITE, and in DONE.
- `start` is ignored when not in IDLE.
- `in_data` is stored bit-exact, with no FP interpretation, except for zero detection.
- Reset mid-job:
  - All state returns to IDLE.
  - The partial word is discarded; no write is issued.
  - Upstream must restart its stream.

## Timing
- All outputs are registered.
- Reset values:
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `zero_cnt`=0.
  - FSM=IDLE, `lane_idx`=0, word counter=0.
- `start` at cycle t → FILL at t+1, so `in_ready`=1 at t+1.
- If the last lane is accepted at t, then `mem_we`=1 at t+1 with the full word.
- If `mem_ready`=1 at cycle w, then at w+1 either `in_ready`=1 (FILL) or `done`=1 (DONE).
- Peak throughput: PACK elements per PACK+1 cycles when `mem_ready` is tied high.
- Zero-word job: `start` at t → `done` at t+1.

## Configuration
- `RELU_WB_ZERO_CNT_EN`
  - **Defined:** `zero_cnt` port exists.
    - Cleared on accepted `start`.
    - Increments per accepted element with `in_data[14:0]`==0 (+0 or −0).
    - Holds its value after `done` until the next `start`.
    - Lets the controller measure post-ReLU sparsity.
  - **Undefined:** the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `tpu_pkg`:
  - `fp16_t` (16-bit typedef)
  - FSM state enum `relu_wb_state_e`
  - `FP16_ZERO_MASK` = 15'h7FFF for zero detection
- One natural sub-module, `relu_wb_packer`:
  - Holds the lane registers and `lane_idx`.
  - Reports `full`.
  - The top level holds the FSM, address/word counters and optional zero counter.

## Test plan
- **Basic pack:** PACK=4, base=0x010, num_words=2, elements 0x3C00,0x4000,0x4200,0x4400,0x0001..0x0004, `mem_ready`=1 → writes 0x4400_4200_4000_3C00 @0x010 and 0x0004_0003_0002_0001 @0x011; `done` pulses 1 cycle after the second write.
- **Backpressure:** `mem_ready` low 5 cycles in WRITE → `mem_we`, address and data stable for all 5 cycles; `in_ready`=0 throughout; exactly one write.
- **Upstream gaps:** `in_valid` toggled 1,0,0,1,… → only handshaked elements are packed, in lane order; no duplicates.
- **Address wrap:** ADDR_W=10, base=0x3FF, num_words=2 → writes at 0x3FF then 0x000.
- **Edge starts:**
  - num_words=0 → `done` one cycle after `start`, no `mem_we`.
  - `start` asserted during FILL → ignored; latched parameters unchanged.
- **Reset and zero count:**
  - `rst_n` low after 2 of 4 lanes → all outputs at reset values, no write.
  - After a new job with inputs 0x0000,0x8000,0x3C00,0x0000 and the macro defined → `zero_cnt`=3.
